load_store_unit: RTL

- Memory stage directly downstream of the instruction decoder.
- Consumes the decoded load, store, memLength and loadUnsigned controls, plus the ALU-computed effective address and the rs2 store data.
- Runs one byte-addressed access against a 32-bit word-wide data memory using a req/ack handshake.
- Returns sign- or zero-extended load data for writeback and flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory stage that sits directly after the instruction decoder. It takes one
// decoded load or store, checks it for alignment/size legality, runs a single
// req/ack transaction against a 32-bit word-wide data memory, and returns
// sign- or zero-extended load data for writeback.
//
// Ports
//   clk, reset        : clock and asynchronous active-low reset
//   start             : request valid, only sampled while ready=1
//   load, store       : decoded access type (exactly one must be set)
//   memLength         : 0=byte, 1=half, 3=word, 2=illegal
//   loadUnsigned      : 1 = zero-extend, 0 = sign-extend sub-word loads
//   address           : effective byte address
//   storeData         : store source, low bits used for byte/half
//   ready             : idle, can accept a request
//   done              : one-cycle completion pulse (success or error)
//   error             : qualified by done
//   loadData          : extended load result, updated only on a good load
//   mem_req/mem_we    : memory request and write strobe, held until mem_ack
//   mem_addr          : word-aligned address
//   mem_byteEn        : byte lane enables
//   mem_wdata         : write data replicated across the selected lanes
//   mem_rdata/mem_ack : memory read data and completion (one cycle)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load,
    input  logic                  store,
    input  logic [1:0]            memLength,
    input  logic                  loadUnsigned,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] storeData,
    output logic                  ready,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byteEn,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int LANES = 4;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_BAD  = 2'd2;
    localparam logic [1:0] LEN_WORD = 2'd3;

    // Last counter value before giving up: mem_req stays high for exactly
    // TIMEOUT cycles when no ack arrives.
    localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                  state_reg,      state_next;
    logic [TO_WIDTH-1:0]     cnt_reg,        cnt_next;
    logic                    error_reg,      error_next;
    logic [DATA_WIDTH-1:0]   load_data_reg,  load_data_next;
    logic                    mem_we_reg,     mem_we_next;
    logic [DATA_WIDTH-1:0]   mem_addr_reg,   mem_addr_next;
    logic [LANES-1:0]        mem_be_reg,     mem_be_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg,  mem_wdata_next;
    logic [1:0]              len_reg,        len_next;
    logic [1:0]              offset_reg,     offset_next;
    logic                    unsigned_reg,   unsigned_next;
    logic                    is_load_reg,    is_load_next;

    // ------------------------------------------------------------------
    // Request decode (combinational, from the live inputs)
    // ------------------------------------------------------------------
    logic                    accept;
    logic                    illegal;
    logic [LANES-1:0]        req_be;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // A start with neither load nor store is not a request at all.
    assign accept  = start && (state_reg == ST_IDLE) && (load || store);

    assign illegal = (load && store)
                  || (memLength == LEN_BAD)
                  || ((memLength == LEN_HALF) && address[0])
                  || ((memLength == LEN_WORD) && (address[1:0] != 2'b00));

    // Per-lane enables and write data. Sub-word stores replicate the source
    // across the word so the memory can simply mask by byte enable.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE      = 2'(gi);
            localparam int         HALF_BASE = 8 * (gi % 2);

            assign req_be[gi] = (memLength == LEN_WORD)
                             || ((memLength == LEN_HALF) && (address[1] == LANE[1]))
                             || ((memLength == LEN_BYTE) && (address[1:0] == LANE));

            assign req_wdata[8*gi +: 8] =
                (memLength == LEN_WORD) ? storeData[8*gi +: 8] :
                (memLength == LEN_HALF) ? storeData[HALF_BASE +: 8] :
                                          storeData[7:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load extraction, driven by the attributes captured at acceptance
    // ------------------------------------------------------------------
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        byte_val = mem_rdata[{offset_reg, 3'b000} +: 8];
        half_val = mem_rdata[{offset_reg[1], 4'b0000} +: 16];
        sign_bit = 1'b0;
        load_ext = mem_rdata;
        case (len_reg)
            LEN_BYTE: begin
                sign_bit = !unsigned_reg && byte_val[7];
                load_ext = {{24{sign_bit}}, byte_val};
            end
            LEN_HALF: begin
                sign_bit = !unsigned_reg && half_val[15];
                load_ext = {{16{sign_bit}}, half_val};
            end
            default: load_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        error_next     = 1'b0;
        load_data_next = load_data_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_be_next    = mem_be_reg;
        mem_wdata_next = mem_wdata_reg;
        len_next       = len_reg;
        offset_next    = offset_reg;
        unsigned_next  = unsigned_reg;
        is_load_next   = is_load_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    len_next      = memLength;
                    offset_next   = address[1:0];
                    unsigned_next = loadUnsigned;
                    is_load_next  = load;
                    if (illegal) begin
                        // Rejected without touching the memory interface.
                        state_next = ST_DONE;
                        error_next = 1'b1;
                    end else begin
                        state_next     = ST_REQ;
                        cnt_next       = '0;
                        mem_we_next    = store;
                        mem_addr_next  = {address[DATA_WIDTH-1:2], 2'b00};
                        mem_be_next    = req_be;
                        mem_wdata_next = req_wdata;
                    end
                end
            end

            ST_REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                    if (is_load_reg) begin
                        load_data_next = load_ext;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                    error_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            error_reg     <= 1'b0;
            load_data_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
            len_reg       <= LEN_BYTE;
            offset_reg    <= 2'b00;
            unsigned_reg  <= 1'b0;
            is_load_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            error_reg     <= error_next;
            load_data_reg <= load_data_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_be_reg    <= mem_be_next;
            mem_wdata_reg <= mem_wdata_next;
            len_reg       <= len_next;
            offset_reg    <= offset_next;
            unsigned_reg  <= unsigned_next;
            is_load_reg   <= is_load_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Handshake flags decode straight from the state register so
    // that an asynchronous reset drops mem_req immediately.
    // ------------------------------------------------------------------
    assign ready      = (state_reg == ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign mem_req    = (state_reg == ST_REQ);
    assign error      = error_reg;
    assign loadData   = load_data_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_byteEn = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule
